// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction engine.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_SOLD_OUT     = 2'd1,
    ERR_INSUFFICIENT = 2'd2,
    ERR_BUSY         = 2'd3
  } err_e;

  localparam logic [7:0] COIN_1 = 8'd1;
  localparam logic [7:0] COIN_2 = 8'd2;
  localparam logic [7:0] COIN_5 = 8'd5;

  localparam int unsigned MAX_ITEMS = 16;

  // Price tables are zero-extended to MAX_ITEMS entries so one helper serves any N_ITEMS.
  function automatic logic [7:0] price_at(input logic [MAX_ITEMS*8-1:0] tbl,
                                          input logic [3:0]             idx);
    return tbl[idx*8 +: 8];
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy 5/2/1 change dispenser with fixed inter-coin pacing.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned DISP_GAP = 1000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] amt_i,
  output logic [7:0] dec_o,
  output logic       done_o,
  output logic       chg_valid_o,
  output logic [7:0] chg_value_o
);

  localparam int unsigned    GAP_W    = $clog2(DISP_GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(DISP_GAP - 1);

  logic             active_q, active_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             chg_valid_q, chg_valid_d;
  logic [7:0]       chg_value_q, chg_value_d;
  logic [7:0]       coin;
  logic             fire;

  assign coin = (amt_i >= COIN_5) ? COIN_5 :
                (amt_i >= COIN_2) ? COIN_2 : COIN_1;

  // The first coin leaves on the start edge; later ones every DISP_GAP edges.
  assign fire = start_i || (active_q && (gap_q == GAP_LAST) && (amt_i != '0));

  always_comb begin
    active_d    = active_q;
    gap_d       = gap_q;
    chg_valid_d = fire;
    chg_value_d = chg_value_q;
    if (start_i) begin
      active_d = 1'b1;
    end else if (active_q && (amt_i == '0)) begin
      active_d = 1'b0;
    end
    if (fire) begin
      gap_d       = '0;
      chg_value_d = coin;
    end else if (active_q) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q    <= 1'b0;
      gap_q       <= '0;
      chg_valid_q <= 1'b0;
      chg_value_q <= '0;
    end else begin
      active_q    <= active_d;
      gap_q       <= gap_d;
      chg_valid_q <= chg_valid_d;
      chg_value_q <= chg_value_d;
    end
  end

  assign dec_o       = fire ? coin : '0;
  assign done_o      = active_q && (amt_i == '0);
  assign chg_valid_o = chg_valid_q;
  assign chg_value_o = chg_value_q;

endmodule

// File: rtl/vend_engine.sv
// Vending transaction engine: credit, stock, purchase FSM, refunds and paced change.
module vend_engine
  import vend_pkg::*;
#(
  parameter int unsigned               N_ITEMS     = 4,
  parameter logic [N_ITEMS*8-1:0]      PRICES      = {8'd7, 8'd5, 8'd3, 8'd2},
  parameter int unsigned               STOCK_MAX   = 9,
  parameter int unsigned               CREDIT_MAX  = 99,
  parameter int unsigned               TIMEOUT_CYC = 100_000_000,
  parameter int unsigned               DISP_GAP    = 1000,
  localparam int unsigned              SEL_W       = $clog2(N_ITEMS),
  localparam int unsigned              STK_W       = $clog2(STOCK_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [7:0]       coin_value,
  input  logic             purchase,
  input  logic             cancel,
  input  logic             restock,
  input  logic [SEL_W-1:0] item_sel,
  output logic [7:0]       credit,
  output logic [STK_W-1:0] stock_sel,
  output logic             vend_valid,
  output logic [SEL_W-1:0] vend_item,
  output logic             chg_valid,
  output logic [7:0]       chg_value,
  output logic             coin_reject,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic [1:0]       state
);

  localparam int unsigned            TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]       TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [MAX_ITEMS*8-1:0] PRICE_TBL = (MAX_ITEMS*8)'(PRICES);
  localparam logic [STK_W-1:0]       STK_FULL  = STK_W'(STOCK_MAX);

  state_e           state_q, state_d;
  logic [7:0]       credit_q, credit_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [STK_W-1:0] stock_q [N_ITEMS];
  logic [STK_W-1:0] stock_d [N_ITEMS];
  logic             vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0] vend_item_q, vend_item_d;
  logic             coin_reject_q, coin_reject_d;
  logic             err_valid_q, err_valid_d;
  err_e             err_code_q, err_code_d;

  logic             disp_start, disp_done;
  logic [7:0]       disp_dec;
  logic             sel_ok, coin_legal, coin_fits, coin_take, stock_dec;
  logic [STK_W-1:0] stk_cur;
  logic [7:0]       price_cur;
  logic [8:0]       credit_sum;

  assign sel_ok     = (32'(item_sel) < N_ITEMS);
  assign stk_cur    = sel_ok ? stock_q[item_sel] : '0;
  assign price_cur  = price_at(PRICE_TBL, 4'(item_sel));
  assign coin_legal = (coin_value == COIN_1) || (coin_value == COIN_2) || (coin_value == COIN_5);
  assign credit_sum = {1'b0, credit_q} + {1'b0, coin_value};
  assign coin_fits  = coin_legal && (credit_sum <= 9'(CREDIT_MAX));

  change_dispenser #(
    .DISP_GAP(DISP_GAP)
  ) u_disp (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (disp_start),
    .amt_i      (credit_q),
    .dec_o      (disp_dec),
    .done_o     (disp_done),
    .chg_valid_o(chg_valid),
    .chg_value_o(chg_value)
  );

  // Purchase effects (credit, stock, vend pulse) register on the accepting edge so
  // they are visible during the single VEND cycle.
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    tmo_d         = tmo_q;
    vend_valid_d  = 1'b0;
    vend_item_d   = vend_item_q;
    coin_reject_d = 1'b0;
    err_valid_d   = 1'b0;
    err_code_d    = err_code_q;
    disp_start    = 1'b0;
    stock_dec     = 1'b0;
    coin_take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (purchase) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_INSUFFICIENT;
        end else if (coin_valid && coin_fits) begin
          coin_take = 1'b1;
          credit_d  = credit_sum[7:0];
          tmo_d     = '0;
          state_d   = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        if (cancel) begin
          disp_start = 1'b1;
          state_d    = ST_CHANGE;
        end else if (purchase) begin
          tmo_d = '0;
          if (stk_cur == '0) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_SOLD_OUT;
          end else if (credit_q < price_cur) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_INSUFFICIENT;
          end else begin
            credit_d     = credit_q - price_cur;
            stock_dec    = 1'b1;
            vend_valid_d = 1'b1;
            vend_item_d  = item_sel;
            state_d      = ST_VEND;
          end
        end else if (coin_valid && coin_fits) begin
          coin_take = 1'b1;
          credit_d  = credit_sum[7:0];
          tmo_d     = '0;
        end else if (tmo_q == TMO_LAST) begin
          disp_start = 1'b1;
          state_d    = ST_CHANGE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_VEND: begin
        if (purchase) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_BUSY;
        end
        if (credit_q != '0) begin
          disp_start = 1'b1;
          state_d    = ST_CHANGE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        if (purchase) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_BUSY;
        end
        if (disp_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (coin_valid && !coin_take) coin_reject_d = 1'b1;
    if (disp_dec != '0) credit_d = credit_q - disp_dec;
  end

  always_comb begin
    for (int unsigned i = 0; i < N_ITEMS; i++) stock_d[i] = stock_q[i];
    if (restock) begin
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_d[i] = STK_FULL;
    end else if (stock_dec) begin
      stock_d[item_sel] = stock_q[item_sel] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      credit_q      <= '0;
      tmo_q         <= '0;
      vend_valid_q  <= 1'b0;
      vend_item_q   <= '0;
      coin_reject_q <= 1'b0;
      err_valid_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= STK_FULL;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      tmo_q         <= tmo_d;
      vend_valid_q  <= vend_valid_d;
      vend_item_q   <= vend_item_d;
      coin_reject_q <= coin_reject_d;
      err_valid_q   <= err_valid_d;
      err_code_q    <= err_code_d;
      for (int unsigned i = 0; i < N_ITEMS; i++) stock_q[i] <= stock_d[i];
    end
  end

  assign credit      = credit_q;
  assign stock_sel   = stk_cur;
  assign vend_valid  = vend_valid_q;
  assign vend_item   = vend_item_q;
  assign coin_reject = coin_reject_q;
  assign err_valid   = err_valid_q;
  assign err_code    = err_code_q;
  assign state       = state_q;

endmodule

// File: tb/tb_vend_engine.sv
// Directed and randomized bench for vend_engine against a transaction-level reference model.
module tb_vend_engine;

  localparam int N    = 4;
  localparam int SMAX = 2;
  localparam int CMAX = 10;
  localparam int TMO  = 50;
  localparam int GAP  = 4;
  localparam logic [31:0] PRICES = {8'd7, 8'd5, 8'd3, 8'd2};

  logic       clk = 1'b0;
  logic       rst_n, coin_valid, purchase, cancel, restock;
  logic [7:0] coin_value;
  logic [1:0] item_sel;
  logic [7:0] credit, chg_value;
  logic [1:0] stock_sel, vend_item, err_code, state;
  logic       vend_valid, chg_valid, coin_reject, err_valid;

  vend_engine #(
    .N_ITEMS(N), .PRICES(PRICES), .STOCK_MAX(SMAX), .CREDIT_MAX(CMAX),
    .TIMEOUT_CYC(TMO), .DISP_GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .purchase(purchase), .cancel(cancel), .restock(restock), .item_sel(item_sel),
    .credit(credit), .stock_sel(stock_sel), .vend_valid(vend_valid), .vend_item(vend_item),
    .chg_valid(chg_valid), .chg_value(chg_value), .coin_reject(coin_reject),
    .err_valid(err_valid), .err_code(err_code), .state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 holding credit, 2 vending, 3 paying change.
  int price_tab [N] = '{2, 3, 5, 7};
  int m_state, m_credit, m_idle, m_gap;
  int m_stock [N];
  int e_vend, e_vitem, e_chg, e_chgv, e_rej, e_err, e_code;
  int cur_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int largest_coin(input int c);
    if (c >= 5) return 5;
    if (c >= 2) return 2;
    return 1;
  endfunction

  task automatic pay_coin();
    e_chg    = 1;
    e_chgv   = largest_coin(m_credit);
    m_credit = m_credit - e_chgv;
    m_gap    = 0;
  endtask

  task automatic raise_err(input int code);
    e_err  = 1;
    e_code = code;
  endtask

  task automatic model_edge(input bit cv, input int v, input bit pu, input bit ca,
                            input bit rs, input int sel, input bit rn);
    bit fits;
    e_vend = 0; e_chg = 0; e_rej = 0; e_err = 0;
    if (!rn) begin
      m_state = 0; m_credit = 0; m_idle = 0; m_gap = 0;
      e_vitem = 0; e_chgv = 0; e_code = 0;
      foreach (m_stock[i]) m_stock[i] = SMAX;
      return;
    end
    fits = (v == 1 || v == 2 || v == 5) && (m_credit + v <= CMAX);
    case (m_state)
      0: begin
        if (pu) begin
          raise_err(2);
          if (cv) e_rej = 1;
        end else if (cv) begin
          if (fits) begin m_credit += v; m_state = 1; m_idle = 0; end
          else e_rej = 1;
        end
      end
      1: begin
        if (ca) begin
          if (cv) e_rej = 1;
          m_state = 3; pay_coin();
        end else if (pu) begin
          if (cv) e_rej = 1;
          m_idle = 0;
          if (m_stock[sel] == 0) raise_err(1);
          else if (m_credit < price_tab[sel]) raise_err(2);
          else begin
            m_credit -= price_tab[sel];
            m_stock[sel]--;
            e_vend = 1; e_vitem = sel; m_state = 2;
          end
        end else if (cv && fits) begin
          m_credit += v; m_idle = 0;
        end else begin
          if (cv) e_rej = 1;
          m_idle++;
          if (m_idle == TMO) begin m_state = 3; pay_coin(); end
        end
      end
      2: begin
        if (cv) e_rej = 1;
        if (pu) raise_err(3);
        if (m_credit > 0) begin m_state = 3; pay_coin(); end
        else m_state = 0;
      end
      default: begin
        if (cv) e_rej = 1;
        if (pu) raise_err(3);
        if (m_credit == 0) m_state = 0;
        else begin
          m_gap++;
          if (m_gap == GAP) pay_coin();
        end
      end
    endcase
    if (rs) foreach (m_stock[i]) m_stock[i] = SMAX;
  endtask

  task automatic step(input bit cv, input int v, input bit pu, input bit ca,
                      input bit rs, input int sel, input bit rn);
    coin_valid = cv; coin_value = 8'(v); purchase = pu; cancel = ca;
    restock = rs; item_sel = 2'(sel); rst_n = rn; cur_sel = sel;
    @(posedge clk);
    model_edge(cv, v, pu, ca, rs, sel, rn);
    @(negedge clk);
    check_eq("state", 32'(state), m_state);
    check_eq("credit", 32'(credit), m_credit);
    check_eq("stock_sel", 32'(stock_sel), m_stock[cur_sel]);
    check_eq("vend_valid", 32'(vend_valid), e_vend);
    check_eq("chg_valid", 32'(chg_valid), e_chg);
    check_eq("coin_reject", 32'(coin_reject), e_rej);
    check_eq("err_valid", 32'(err_valid), e_err);
    if (e_vend != 0) check_eq("vend_item", 32'(vend_item), e_vitem);
    if (e_chg != 0)  check_eq("chg_value", 32'(chg_value), e_chgv);
    if (e_err != 0)  check_eq("err_code", 32'(err_code), e_code);
    if (!rn) begin
      check_eq("rst_vend_item", 32'(vend_item), 0);
      check_eq("rst_chg_value", 32'(chg_value), 0);
      check_eq("rst_err_code", 32'(err_code), 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_state != 0 && k < 200) begin idle(1); k++; end
    check_eq("drain_to_idle", 32'(state), 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("reset_state", 32'(state), 0);
    check_eq("reset_credit", 32'(credit), 0);
    check_eq("reset_stock", 32'(stock_sel), SMAX);

    // Purchase item 1 (price 3) from credit 7, change 2 + 2.
    step(1, 5, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0, 1);
    check_eq("credit7", 32'(credit), 7);
    step(0, 0, 1, 0, 0, 1, 1);
    check_eq("vend_pulse", 32'(vend_valid), 1);
    check_eq("vend_item1", 32'(vend_item), 1);
    check_eq("vend_credit", 32'(credit), 4);
    idle(1);
    check_eq("chg1_val", 32'(chg_value), 2);
    idle(3);
    check_eq("gap_quiet", 32'(chg_valid), 0);
    idle(1);
    check_eq("chg2_val", 32'(chg_value), 2);
    check_eq("chg2_valid", 32'(chg_valid), 1);
    idle(1);
    check_eq("back_idle", 32'(state), 0);

    // Credit ceiling and illegal coin.
    step(1, 5, 0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    check_eq("ceil_credit", 32'(credit), 10);
    check_eq("ceil_reject", 32'(coin_reject), 1);
    step(1, 3, 0, 0, 0, 0, 1);
    check_eq("illegal_reject", 32'(coin_reject), 1);
    step(0, 0, 0, 1, 0, 0, 1);
    drain();

    // Sold out, then restock, then restock coincident with a vend.
    for (int b = 0; b < 2; b++) begin
      step(1, 2, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0, 1);
      drain();
    end
    check_eq("stock_empty", 32'(stock_sel), 0);
    step(1, 2, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 1);
    check_eq("sold_out_err", 32'(err_code), 1);
    check_eq("sold_out_credit", 32'(credit), 2);
    step(0, 0, 0, 0, 1, 0, 1);
    check_eq("restocked", 32'(stock_sel), SMAX);
    step(0, 0, 1, 0, 1, 0, 1);
    check_eq("restock_wins_vend", 32'(vend_valid), 1);
    check_eq("restock_wins_stock", 32'(stock_sel), SMAX);
    drain();

    // Inactivity refund.
    step(1, 5, 0, 0, 0, 0, 1);
    idle(TMO - 1);
    check_eq("pre_timeout", 32'(state), 1);
    idle(1);
    check_eq("timeout_state", 32'(state), 3);
    check_eq("timeout_chg", 32'(chg_value), 5);
    idle(1);
    check_eq("timeout_done", 32'(state), 0);

    // cancel + purchase + coin together with credit 3.
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0, 0, 1);
    check_eq("simul_chg", 32'(chg_value), 2);
    check_eq("simul_reject", 32'(coin_reject), 1);
    check_eq("simul_no_vend", 32'(vend_valid), 0);
    drain();

    // Reset while paying change.
    step(1, 5, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0, 1);
    check_eq("mid_change", 32'(state), 3);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_mid_credit", 32'(credit), 0);
    idle(10);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 0, 0, 0, i, 1);
      check_eq("rst_stock_full", 32'(stock_sel), SMAX);
    end

    // Randomized traffic: a busy phase then a sparse one that lets timeouts expire.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 2500; i++) begin
        int coin_tab [6] = '{1, 2, 5, 5, 3, 200};
        int cpct;
        bit cv, pu, ca, rs, rn;
        cpct = (ph == 0) ? 30 : 4;
        cv = ($urandom_range(0, 99) < cpct);
        pu = ($urandom_range(0, 99) < ((ph == 0) ? 10 : 2));
        ca = ($urandom_range(0, 99) < ((ph == 0) ? 3 : 1));
        rs = ($urandom_range(0, 99) < 2);
        rn = !($urandom_range(0, 999) < 3);
        step(cv, coin_tab[$urandom_range(0, 5)], pu, ca, rs, $urandom_range(0, N - 1), rn);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vend_engine.md
# vend_engine

Parametrised vending transaction engine, the next-generation core behind the vending machine top level. It supports N items with per-item stock counters and a parameter price table. It validates and saturates coin credit, executes purchases, and returns change coin-by-coin (greedy 5/2/1) with a paced dispenser. It adds cancel and inactivity-timeout refunds. It consumes debounced single-cycle pulses from the coin and button front end and feeds the display, LED and sound blocks.

## Interface
- N_ITEMS, 4, number of selectable items (2..16); SEL_W = $clog2(N_ITEMS)
- PRICES, {8'd7,8'd5,8'd3,8'd2}, flat N_ITEMS×8 vector; item i price = PRICES[8*i +: 8]; every price ≥ 1
- STOCK_MAX, 9, restock/reset level per item; STK_W = $clog2(STOCK_MAX+1)
- CREDIT_MAX, 99, credit ceiling
- TIMEOUT_CYC, 100_000_000, idle cycles in CREDIT before auto-refund
- DISP_GAP, 1000, cycles between change coins (≥ 2)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  reset, synchronous, active-low
- coin_valid  in  1  one-cycle coin strobe
- coin_value  in  8  coin denomination; legal values 1, 2, 5
- purchase  in  1  one-cycle purchase strobe
- cancel  in  1  one-cycle refund request
- restock  in  1  one-cycle pulse; sets all stock counters to STOCK_MAX
- item_sel  in  SEL_W  selected item
- credit  out  8  current credit
- stock_sel  out  STK_W  stock of item_sel (combinational read of registered counters)
- vend_valid  out  1  one-cycle pulse; item dispensed
- vend_item  out  SEL_W  item dispensed; valid with vend_valid
- chg_valid  out  1  one-cycle pulse; one change coin released
- chg_value  out  8  change coin value (5/2/1); valid with chg_valid
- coin_reject  out  1  one-cycle pulse; coin not accepted
- err_valid  out  1  one-cycle pulse; err_code valid
- err_code  out  2  0 NONE, 1 SOLD_OUT, 2 INSUFFICIENT, 3 BUSY
- state  out  2  0 IDLE, 1 CREDIT, 2 VEND, 3 CHANGE

## Operation
- **IDLE** (credit = 0)
  - An accepted coin goes to CREDIT.
  - purchase → err INSUFFICIENT.
  - cancel is ignored.
- **CREDIT**
  - An accepted coin adds coin_value to credit and reloads the timeout counter.
  - A coin is rejected (coin_reject, credit unchanged) if its value is illegal or if credit + value > CREDIT_MAX.
- **purchase in CREDIT**
  - If stock[item_sel] = 0 → err SOLD_OUT; state and credit are unchanged.
  - Otherwise, if credit < price → err INSUFFICIENT; state and credit are unchanged.
  - Otherwise → VEND.
- **cancel in CREDIT**, or the timeout counter reaching TIMEOUT_CYC → CHANGE with the full credit.
- **Priority in one cycle:** cancel > purchase > coin. A coin that loses to purchase or cancel is rejected.
- **VEND** (1 cycle)
  - vend_valid = 1 and vend_item = the latched selection.
  - stock[item] decrements and credit -= price.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- **CHANGE**
  - Releases the largest of 5/2/1 that is ≤ credit and subtracts it in the same cycle.
  - Coins are spaced exactly DISP_GAP cycles apart.
  - Returns to IDLE on the cycle after credit reaches 0.
- **During VEND/CHANGE**
  - Coins are rejected.
  - purchase → err BUSY.
  - cancel is ignored.
- **restock** is accepted in any state. If it coincides with a VEND decrement, restock wins (the counter becomes STOCK_MAX).
- **Reset**
  - state IDLE; credit 0; all stocks STOCK_MAX.
  - All pulses, vend_item, chg_value and err_code are 0; timers cleared.
  - Reset mid-CHANGE abandons the remaining change; no further chg_valid.
- **Width rules:** credit + coin is computed 9-bit before the comparison. Stock never underflows; a decrement is only issued with stock > 0.

## Timing
- A strobe sampled at edge k takes effect at edge k+1. All outputs are registered except stock_sel.
- purchase at edge k → state VEND and vend_valid during cycle k+1 → first chg_valid in cycle k+2 → subsequent coins every DISP_GAP cycles.
- cancel or timeout at edge k → first chg_valid in cycle k+1.
- coin_reject and err_valid are asserted in the cycle after the offending strobe.
- Timeout is measured from the last accepted coin or purchase attempt; it counts only in CREDIT.

## Structure
- **vend_pkg:** state encoding, err_code values, legal coin constants (1/2/5), and a price-extract function.
- **change_dispenser sub-module:**
  - Contains the greedy selector, the DISP_GAP pacing counter and the credit-decrement request.
  - Started by the FSM with the remaining credit; signals done.
- The top of the block holds the FSM, the credit register, the timeout counter and an N_ITEMS×STK_W stock array.

## Test plan
- **Purchase with change.** Defaults with DISP_GAP=4: coins 5, 2 (credit 7); item_sel=1; purchase → vend_valid with vend_item=1, credit 4; then chg 2, chg 2 four cycles apart; state back to IDLE.
- **Credit ceiling.** CREDIT_MAX=10: coins 5, 5, 1 → credit 10; the third coin gets coin_reject. Coin value 3 → coin_reject.
- **Sold out and restock.** STOCK_MAX=2, item0: buy twice → stock_sel 0; a third purchase → err SOLD_OUT, credit unchanged. restock → stock_sel 2. restock coincident with a vend of item0 → 2.
- **Timeout refund.** TIMEOUT_CYC=50: coin 5, then idle → at 50 cycles state CHANGE and a single chg 5; then IDLE.
- **Simultaneous strobes.** cancel + purchase + coin in the same cycle with credit 3 → refund of 2 then 1; coin_reject; no vend_valid.
- **Reset mid-operation.** rst_n low for one cycle in CHANGE with credit 7 → credit 0, state IDLE, no chg_valid afterwards, all stocks at STOCK_MAX.
